threshold_multi: RTL and testbench
==================================

# threshold_multi

Multi-channel successor to the single-channel threshold detector in the acoustic-localisation chain. It sits after the per-microphone CIC decimators and watches CHANNELS filtered sample streams that share one strobe. It timestamps the first upward threshold crossing on each channel and reports the complete set of timestamps once every channel has fired within a coincidence window. Re-arming uses hysteresis (HIGH/LOW) and a quiet-period count, so one acoustic event produces exactly one report.

## Interface
- CHANNELS, 4: number of input channels (≥1).
- DATA_W, 32: sample width, unsigned.
- TIME_W, 32: timestamp width.
- WINDOW, 64: coincidence window in strobes, counted from the first trigger (≥1).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- data  in  CHANNELS*DATA_W  samples; channel k occupies bits [k*DATA_W +: DATA_W].
- data_valid  in  1  one-cycle strobe; all channels are valid together.
- HIGH  in  DATA_W  trigger threshold.
- LOW  in  DATA_W  quiet threshold.
- zero_num  in  32  number of consecutive all-quiet strobes required to re-arm.
- ack  in  1  consumer acknowledge of a report.
- valid  out  1  report available; held until ack.
- timeout  out  1  one-cycle pulse when a window expires incomplete.
- detect_time  out  CHANNELS*TIME_W  per-channel trigger timestamps, same packing as data.
- trig_mask  out  CHANNELS  channels triggered in the current event.

## Operation
- Sample counter `ts`: increments by 1 (mod 2^TIME_W) on every data_valid, in every state. A sample's timestamp is the `ts` value before that strobe's increment.
- Comparisons are unsigned and are evaluated only on data_valid.
  - Trigger: data > HIGH (strict).
  - Quiet: data ≤ LOW.
- HIGH, LOW and zero_num are sampled live and are not latched. LOW ≥ HIGH is legal; behaviour follows the rules literally.
- FSM:
  - IDLE: trig_mask = 0. On a strobe where any channel triggers, set those mask bits, load their detect_time slots with the timestamp, and clear the window counter `wc`. Go to REPORT if the mask is now all ones, otherwise to COLLECT.
  - COLLECT: on each strobe, untriggered channels that trigger set their bit and load their timestamp. A channel that has already triggered never reloads. `wc` increments per strobe.
    - Mask all ones → REPORT. This takes priority over expiry on the same strobe.
    - Otherwise, `wc` reaching WINDOW → pulse timeout, go to QUIET. The mask and times are kept for debug.
  - REPORT: valid = 1. Strobes still advance `ts` but do not change captured data. ack = 1 → go to QUIET, valid = 0.
  - QUIET: quiet counter `qc` counts consecutive strobes on which all channels are quiet. Any non-quiet strobe clears `qc`.
    - `qc` = zero_num → go to IDLE and clear trig_mask.
    - zero_num = 0 → go to IDLE on the next clock with no strobe needed.
- ack outside REPORT is ignored. ack may be held high; only its level in REPORT matters.
- Channels that trigger simultaneously on the same strobe receive identical timestamps.

## Timing
- All outputs are registered.
- Reset (rst = 0, asynchronous): state IDLE; ts, wc, qc = 0; valid = 0; timeout = 0; trig_mask = 0; detect_time = 0. Reset mid-event discards the event with no report.
- valid rises on the clk edge that samples the completing strobe, so it is visible in the following cycle.
- valid falls on the edge that samples ack = 1. Minimum valid width is 1 clk.
- timeout is high for exactly one clk, on the edge of the expiring strobe.
- trig_mask and detect_time update on the edge that samples the triggering strobe.
- Back-to-back strobes (data_valid high on consecutive clks) must be supported; there is no throughput limit.
- ts wrap: timestamps wrap modulo 2^TIME_W. Differences are the consumer's responsibility.
- wc and qc saturate and never wrap.

## Test plan
- CHANNELS=4, HIGH=150, LOW=20, zero_num=3, WINDOW=8. Strobe 0 is all zeros; strobe 1 sends {160,0,0,0}; strobe 2 sends {170,155,0,0}; strobe 3 sends {0,0,151,200}. Required: valid=1 with times {1,2,3,3}; ch0 is not overwritten at strobe 2.
- Continuing: ack=1 for 1 clk, then strobes {0,0,0,0}, {30,0,0,0}, then three all-zero strobes. Required: re-arm only after the last three; a trigger during QUIET is ignored; next event times are fresh.
- Window expiry: only ch0 at 160, then 8 strobes with no other trigger. Required: timeout pulse of 1 clk, valid never rises, trig_mask=0001.
- Completion and expiry on the same strobe: the last channel triggers on the strobe where wc reaches WINDOW. Required: valid=1 and timeout=0.
- Boundaries: data equal to HIGH never triggers; data equal to LOW counts as quiet; zero_num=0 re-arms one clk after ack; with TIME_W=4, a trigger at ts=15 then 0 reports {15,0}.
- Reset asserted in COLLECT and in REPORT: all outputs 0 immediately; after release the first trigger is stamped relative to ts=0.

Source files
------------

// File: rtl/threshold_multi.sv
// Multi-channel threshold detector: timestamps the first upward crossing
// per channel and reports once every channel fires inside a window.
module threshold_multi #(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 32,
  parameter int TIME_W   = 32,
  parameter int WINDOW   = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS*DATA_W-1:0] data,
  input  logic                       data_valid,
  input  logic [DATA_W-1:0]          HIGH,
  input  logic [DATA_W-1:0]          LOW,
  input  logic [31:0]                zero_num,
  input  logic                       ack,
  output logic                       valid,
  output logic                       timeout,
  output logic [CHANNELS*TIME_W-1:0] detect_time,
  output logic [CHANNELS-1:0]        trig_mask
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_REPORT,
    S_QUIET
  } state_t;

  state_t state, state_nx;

  logic [TIME_W-1:0]   ts;
  logic [31:0]         wc, wc_nx, wc_inc;
  logic [31:0]         qc, qc_nx, qc_inc;
  logic [CHANNELS-1:0] hit, quiet;
  logic [CHANNELS-1:0] mask_nx, load;
  logic                valid_nx, timeout_nx;
  logic                all_quiet;

  always_comb begin
    hit   = '0;
    quiet = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      hit[k]   = data[k*DATA_W +: DATA_W] > HIGH;
      quiet[k] = data[k*DATA_W +: DATA_W] <= LOW;
    end
  end

  assign all_quiet = &quiet;
  assign wc_inc    = (&wc) ? wc : wc + 32'd1;
  assign qc_inc    = (&qc) ? qc : qc + 32'd1;

  always_comb begin
    state_nx   = state;
    mask_nx    = trig_mask;
    load       = '0;
    wc_nx      = wc;
    qc_nx      = qc;
    valid_nx   = valid;
    timeout_nx = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (data_valid && (|hit)) begin
          load     = hit;
          mask_nx  = hit;
          wc_nx    = '0;
          valid_nx = &hit;
          state_nx = (&hit) ? S_REPORT : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (data_valid) begin
          load    = hit & ~trig_mask;
          mask_nx = trig_mask | hit;
          wc_nx   = wc_inc;
          // completion wins over expiry on the same strobe
          if (&mask_nx) begin
            valid_nx = 1'b1;
            state_nx = S_REPORT;
          end else if (wc_inc >= 32'(WINDOW)) begin
            timeout_nx = 1'b1;
            qc_nx      = '0;
            state_nx   = S_QUIET;
          end
        end
      end
      S_REPORT: begin
        if (ack) begin
          valid_nx = 1'b0;
          qc_nx    = '0;
          state_nx = S_QUIET;
        end
      end
      S_QUIET: begin
        if (data_valid) begin
          qc_nx = all_quiet ? qc_inc : '0;
        end
        if (qc_nx >= zero_num) begin
          mask_nx  = '0;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      ts          <= '0;
      wc          <= '0;
      qc          <= '0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
      trig_mask   <= '0;
      detect_time <= '0;
    end else begin
      state     <= state_nx;
      wc        <= wc_nx;
      qc        <= qc_nx;
      valid     <= valid_nx;
      timeout   <= timeout_nx;
      trig_mask <= mask_nx;
      if (data_valid) begin
        ts <= ts + TIME_W'(1);
      end
      for (int k = 0; k < CHANNELS; k++) begin
        if (load[k]) begin
          detect_time[k*TIME_W +: TIME_W] <= ts;
        end
      end
    end
  end

endmodule

// File: tb/tb_threshold_multi.sv
// Directed bench for threshold_multi: capture, re-arm, expiry,
// boundaries, reset and timestamp wrap.
module tb_threshold_multi;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] data = '0;
  logic         data_valid = 1'b0;
  logic [31:0]  high = 32'd150;
  logic [31:0]  low = 32'd20;
  logic [31:0]  zero_num = 32'd3;
  logic         ack = 1'b0;
  logic         valid, timeout;
  logic [127:0] detect_time;
  logic [3:0]   trig_mask;

  logic [15:0]  data_w = '0;
  logic         dv_w = 1'b0;
  logic [7:0]   high_w = 8'd150;
  logic [7:0]   low_w = 8'd20;
  logic [31:0]  zn_w = 32'd1;
  logic         ack_w = 1'b0;
  logic         valid_w, timeout_w;
  logic [7:0]   detect_w;
  logic [1:0]   mask_w;

  int nvec = 0;
  int nerr = 0;

  threshold_multi #(
    .CHANNELS(4), .DATA_W(32), .TIME_W(32), .WINDOW(8)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
    .HIGH(high), .LOW(low), .zero_num(zero_num), .ack(ack),
    .valid(valid), .timeout(timeout),
    .detect_time(detect_time), .trig_mask(trig_mask)
  );

  threshold_multi #(
    .CHANNELS(2), .DATA_W(8), .TIME_W(4), .WINDOW(4)
  ) dut_w (
    .clk(clk), .rst(rst), .data(data_w), .data_valid(dv_w),
    .HIGH(high_w), .LOW(low_w), .zero_num(zn_w), .ack(ack_w),
    .valid(valid_w), .timeout(timeout_w),
    .detect_time(detect_w), .trig_mask(mask_w)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  function automatic logic [127:0] pk(input logic [31:0] t0, t1, t2, t3);
    return {t3, t2, t1, t0};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [31:0] a0, a1, a2, a3);
    @(negedge clk);
    data = pk(a0, a1, a2, a3);
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) strobe(0, 0, 0, 0);
  endtask

  task automatic strobe_w(input logic [7:0] a0, a1);
    @(negedge clk);
    data_w = {a1, a0};
    dv_w = 1'b1;
    @(negedge clk);
    dv_w = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", 128'(valid), 128'd0);
    chk("rst_timeout", 128'(timeout), 128'd0);
    chk("rst_mask", 128'(trig_mask), 128'd0);
    chk("rst_time", detect_time, 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // 4-bit timestamp wrap on the small instance
    for (int i = 0; i < 15; i++) strobe_w(0, 0);
    strobe_w(160, 0);
    chk("wrap_mask1", 128'(mask_w), 128'd1);
    strobe_w(0, 160);
    chk("wrap_valid", 128'(valid_w), 128'd1);
    chk("wrap_time", 128'(detect_w), 128'h0F);

    // first event: times {1,2,3,3}
    strobe(0, 0, 0, 0);
    strobe(160, 0, 0, 0);
    chk("ev1_mask_a", 128'(trig_mask), 128'h1);
    chk("ev1_valid_a", 128'(valid), 128'd0);
    strobe(170, 155, 0, 0);
    chk("ev1_mask_b", 128'(trig_mask), 128'h3);
    chk("ev1_time_b", detect_time, pk(1, 2, 0, 0));
    strobe(0, 0, 151, 200);
    chk("ev1_valid", 128'(valid), 128'd1);
    chk("ev1_time", detect_time, pk(1, 2, 3, 3));
    chk("ev1_timeout", 128'(timeout), 128'd0);
    repeat (2) @(negedge clk);
    chk("ev1_valid_held", 128'(valid), 128'd1);

    // ack, then quiet period with interruptions
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ack_valid", 128'(valid), 128'd0);
    strobe(0, 0, 0, 0);
    strobe(30, 0, 0, 0);
    strobe(200, 0, 0, 0);
    chk("quiet_ignore_time", detect_time, pk(1, 2, 3, 3));
    chk("quiet_ignore_valid", 128'(valid), 128'd0);
    strobe(20, 20, 20, 20);
    strobe(0, 0, 0, 0);
    chk("quiet_not_rearmed", 128'(trig_mask), 128'hF);
    strobe(0, 0, 0, 0);
    chk("quiet_rearmed", 128'(trig_mask), 128'h0);

    // simultaneous triggers, fresh timestamps (ts=10)
    strobe(160, 160, 160, 160);
    chk("ev2_valid", 128'(valid), 128'd1);
    chk("ev2_time", detect_time, pk(10, 10, 10, 10));

    // zero_num = 0 re-arms one clk after ack
    zero_num = 32'd0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("zn0_valid", 128'(valid), 128'd0);
    chk("zn0_mask_kept", 128'(trig_mask), 128'hF);
    @(negedge clk);
    chk("zn0_mask_clr", 128'(trig_mask), 128'h0);
    zero_num = 32'd3;

    // data equal to HIGH never triggers (ts=11)
    strobe(150, 150, 150, 150);
    chk("eq_high_mask", 128'(trig_mask), 128'h0);

    // window expiry, ack held high throughout (ts=12)
    ack = 1'b1;
    strobe(160, 0, 0, 0);
    zeros(7);
    chk("exp_no_timeout", 128'(timeout), 128'd0);
    strobe(0, 0, 0, 0);
    chk("exp_timeout", 128'(timeout), 128'd1);
    chk("exp_mask", 128'(trig_mask), 128'h1);
    chk("exp_valid", 128'(valid), 128'd0);
    @(negedge clk);
    chk("exp_pulse_end", 128'(timeout), 128'd0);
    chk("exp_time0", 128'(detect_time[31:0]), 128'd12);
    ack = 1'b0;
    zeros(3);
    chk("exp_rearm", 128'(trig_mask), 128'h0);

    // completion on the expiring strobe (first at ts=24)
    strobe(160, 160, 160, 0);
    zeros(7);
    strobe(0, 0, 0, 200);
    chk("tie_valid", 128'(valid), 128'd1);
    chk("tie_timeout", 128'(timeout), 128'd0);
    chk("tie_time", detect_time, pk(24, 24, 24, 32));

    // reset while in REPORT
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstrep_valid", 128'(valid), 128'd0);
    chk("rstrep_mask", 128'(trig_mask), 128'd0);
    chk("rstrep_time", detect_time, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    strobe(160, 0, 0, 0);
    chk("rstrep_restamp", detect_time, pk(0, 0, 0, 0));
    chk("rstrep_mask2", 128'(trig_mask), 128'h1);

    // reset while in COLLECT
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstcol_mask", 128'(trig_mask), 128'd0);
    chk("rstcol_timeout", 128'(timeout), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    strobe(0, 0, 0, 0);
    strobe(0, 160, 0, 0);
    chk("rstcol_restamp", detect_time, pk(0, 1, 0, 0));
    chk("rstcol_mask2", 128'(trig_mask), 128'h2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
